// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit: command bit positions, FSM states, iteration count.
// Optional build macro MD_FAST_MUL_EN is consumed in md_unit.sv.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int ITER     = MD_WIDTH;

  // md_op one-hot bit positions
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;

  // hilo_op one-hot bit positions
  localparam int HL_MFHI = 0;
  localparam int HL_MFLO = 1;
  localparam int HL_MTHI = 2;
  localparam int HL_MTLO = 3;

  localparam logic [3:0] MFHI_CODE = 4'b0001;
  localparam logic [3:0] MFLO_CODE = 4'b0010;
  localparam logic [3:0] MTHI_CODE = 4'b0100;
  localparam logic [3:0] MTLO_CODE = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/md_if.sv
// CPU <-> multiply/divide unit bus: command inputs, HI/LO state, status and FSM debug view.
interface md_if #(
  parameter int WIDTH = 32
);

  // Handshake: md_start is a one-cycle request that is accepted only on an edge where
  // busy is low; a request seen while busy is dropped, never queued. done pulses for
  // one cycle once HI/LO hold the new result and busy has fallen.
  logic                   md_start;
  logic [3:0]             md_op;
  logic [WIDTH-1:0]       rs_data;
  logic [WIDTH-1:0]       rt_data;
  logic [3:0]             hilo_op;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;
  logic [WIDTH-1:0]       hilo_rdata;
  md_pkg::md_state_e      dbg_state;

  modport master (
    output md_start, md_op, rs_data, rt_data, hilo_op,
    input  busy, done, hi, lo, hilo_rdata, dbg_state
  );

  modport slave (
    input  md_start, md_op, rs_data, rt_data, hilo_op,
    output busy, done, hi, lo, hilo_rdata, dbg_state
  );

endinterface

// File: rtl/md_iter_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply or restoring divide, one step per enable.
// A single 2W accumulator {acc_hi, acc_lo} holds product, or remainder/quotient.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;

  // Multiply: lo_q holds the multiplier and shifts right as product bits enter from above.
  assign add_sum = {1'b0, hi_q} + ({1'b0, b_q} & {(WIDTH+1){lo_q[0]}});
  // Divide: remainder is always below the divisor, so trial[WIDTH] is a clean borrow flag.
  assign trial   = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= is_div ? op_a : op_b;
      b_q   <= is_div ? op_b : op_a;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (!trial[WIDTH]) begin
          hi_q <= trial[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[WIDTH:1];
        lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MFxx/MTxx access.
// Build option: define MD_FAST_MUL_EN for a single-cycle combinational multiply path.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e          state_q, state_n;
  logic               accept;
  logic               busy_q, done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, rs_raw_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;

  logic               op_is_div, op_is_signed, rs_neg, rt_neg, div_zero;
  logic [WIDTH-1:0]   rs_abs, rt_abs, core_hi, core_lo;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] mul_raw, mul_fix;

  assign op_is_div    = bus.md_op[OP_DIV] | bus.md_op[OP_DIVU];
  assign op_is_signed = bus.md_op[OP_MULT] | bus.md_op[OP_DIV];
  assign rs_neg       = op_is_signed & bus.rs_data[WIDTH-1];
  assign rt_neg       = op_is_signed & bus.rt_data[WIDTH-1];
  assign rs_abs       = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
  assign rt_abs       = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
  assign div_zero     = op_is_div && (bus.rt_data == '0);

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.md_start && is_onehot4(bus.md_op)) begin
          accept = 1'b1;
          if (div_zero) state_n = FIX;
`ifdef MD_FAST_MUL_EN
          else if (!op_is_div) state_n = FIX;
`endif
          else state_n = RUN;
        end
      end
      RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state_q == RUN),
    .is_div (op_is_div),
    .op_a   (rs_abs),
    .op_b   (rt_abs),
    .acc_hi (core_hi),
    .acc_lo (core_lo)
  );

`ifdef MD_FAST_MUL_EN
  logic [WIDTH-1:0] fa_q, fb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_q <= '0;
      fb_q <= '0;
    end else if (accept) begin
      fa_q <= rs_abs;
      fb_q <= rt_abs;
    end
  end
  assign mul_raw = {{WIDTH{1'b0}}, fa_q} * {{WIDTH{1'b0}}, fb_q};
`else
  assign mul_raw = {core_hi, core_lo};
`endif

  // Magnitudes were computed unsigned; restore signs here. -2^(W-1)/-1 wraps naturally.
  assign mul_fix = neg_res_q ? (~mul_raw + 1'b1) : mul_raw;

  always_comb begin
    fix_hi = mul_fix[2*WIDTH-1:WIDTH];
    fix_lo = mul_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        fix_hi = rs_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = neg_rem_q ? (~core_hi + 1'b1) : core_hi;
        fix_lo = neg_res_q ? (~core_lo + 1'b1) : core_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_raw_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_q == FIX);
      if (accept) begin
        cnt_q     <= '0;
        is_div_q  <= op_is_div;
        neg_res_q <= rs_neg ^ rt_neg;
        neg_rem_q <= rs_neg;
        dz_q      <= div_zero;
        rs_raw_q  <= bus.rs_data;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // An accepted md_start suppresses a same-cycle MTHI/MTLO.
      if (state_q == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (!busy_q && !accept) begin
        if (bus.hilo_op == MTHI_CODE) hi_q <= bus.rs_data;
        if (bus.hilo_op == MTLO_CODE) lo_q <= bus.rs_data;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.dbg_state  = state_q;
  assign bus.hilo_rdata = (bus.hilo_op == MFHI_CODE) ? hi_q :
                          (bus.hilo_op == MFLO_CODE) ? lo_q : '0;

endmodule
